// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// The JR state only exists when MC_CTRL_JR_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_RTYPE  = 4'd6,
    ST_ADDI   = 4'd7,
    ST_BRCMP  = 4'd8,
    ST_BRTGT  = 4'd9,
    ST_JUMP   = 4'd10
`ifdef MC_CTRL_JR_EN
    , ST_JR   = 4'd11
`endif
  } mc_state_e;

  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_J    = 6'b000010;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SELB_RT     = 2'b00;
  localparam logic [1:0] SELB_FOUR   = 2'b01;
  localparam logic [1:0] SELB_IMM    = 2'b10;
  localparam logic [1:0] SELB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU = 2'b00;
  localparam logic [1:0] PCSRC_BRT = 2'b01;
  localparam logic [1:0] PCSRC_TGT = 2'b10;
  localparam logic [1:0] PCSRC_RS  = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_control;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_sel_a;
    logic       target_write;
    logic [1:0] alu_sel_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       instr_done;
  } mc_ctrl_t;

  function automatic logic opc_legal(input logic [5:0] opc);
    return (opc == OPC_R) || (opc == OPC_LW) || (opc == OPC_SW) ||
           (opc == OPC_BEQ) || (opc == OPC_J) || (opc == OPC_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore output decode: maps the controller state to datapath strobes.
// Includes the JR state decode when MC_CTRL_JR_EN is defined.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  mc_state_e state_i,
  input  logic      br_taken_i,
  output mc_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_sel_b = SELB_FOUR;
        ctrl_o.pc_write  = 1'b1;
      end
      ST_DECODE: ctrl_o.target_write = 1'b1;
      ST_MEMADR: begin
        ctrl_o.alu_sel_a = 1'b1;
        ctrl_o.alu_sel_b = SELB_IMM;
      end
      ST_MEMRD: begin
        ctrl_o.iord      = 1'b1;
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_sel_a = 1'b1;
        ctrl_o.alu_sel_b = SELB_IMM;
      end
      ST_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.alu_sel_a  = 1'b1;
        ctrl_o.alu_sel_b  = SELB_IMM;
        ctrl_o.instr_done = 1'b1;
      end
      ST_RTYPE: begin
        ctrl_o.alu_sel_a  = 1'b1;
        ctrl_o.alu_sel_b  = SELB_RT;
        ctrl_o.alu_op     = ALUOP_FUNCT;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_ADDI: begin
        ctrl_o.alu_sel_a  = 1'b1;
        ctrl_o.alu_sel_b  = SELB_IMM;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      ST_BRCMP: begin
        ctrl_o.alu_sel_a = 1'b1;
        ctrl_o.alu_sel_b = SELB_RT;
        ctrl_o.alu_op    = ALUOP_SUB;
      end
      // PC already holds PC+4, so the ALU forms PC+4+(imm<<2) here.
      ST_BRTGT: begin
        ctrl_o.alu_sel_b  = SELB_IMMSH2;
        ctrl_o.pc_src     = PCSRC_BRT;
        ctrl_o.pc_write   = br_taken_i;
        ctrl_o.instr_done = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_TGT;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MC_CTRL_JR_EN
      ST_JR: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_RS;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: state register, branch flag, retire counter.
// Define MC_CTRL_JR_EN to route R-type fn=001000 to a dedicated JR state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opc,
  input  logic [5:0]       fn,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             PCWriteControl,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSelA,
  output logic             TargetWrite,
  output logic [1:0]       ALUSelB,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUOp,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       dbg_state_o
);

  mc_state_e        state_q, state_d;
  logic             br_taken_q;
  logic [CNT_W-1:0] cnt_q;
  mc_ctrl_t         ctrl, ctrl_g;

`ifndef MC_CTRL_JR_EN
  logic unused_fn;
  assign unused_fn = ^fn;
`endif

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opc)
          OPC_LW, OPC_SW: state_d = ST_MEMADR;
          OPC_R: begin
            state_d = ST_RTYPE;
`ifdef MC_CTRL_JR_EN
            if (fn == FN_JR) state_d = ST_JR;
`endif
          end
          OPC_ADDI: state_d = ST_ADDI;
          OPC_BEQ:  state_d = ST_BRCMP;
          OPC_J:    state_d = ST_JUMP;
          default:  state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (opc == OPC_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_BRCMP:  state_d = ST_BRTGT;
      default:   state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      br_taken_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_BRCMP) br_taken_q <= Zero;
      if (ctrl.instr_done) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  mc_ctrl_decode u_decode (
    .state_i    (state_q),
    .br_taken_i (br_taken_q),
    .ctrl_o     (ctrl)
  );

  // Reset masks every output combinationally so an aborted instruction writes nothing.
  assign ctrl_g         = reset ? '0 : ctrl;
  assign PCWrite        = ctrl_g.pc_write;
  assign PCWriteControl = ctrl_g.pc_write_control;
  assign IorD           = ctrl_g.iord;
  assign MemRead        = ctrl_g.mem_read;
  assign MemWrite       = ctrl_g.mem_write;
  assign IRWrite        = ctrl_g.ir_write;
  assign MemtoReg       = ctrl_g.mem_to_reg;
  assign RegWrite       = ctrl_g.reg_write;
  assign RegDst         = ctrl_g.reg_dst;
  assign ALUSelA        = ctrl_g.alu_sel_a;
  assign TargetWrite    = ctrl_g.target_write;
  assign ALUSelB        = ctrl_g.alu_sel_b;
  assign PCSrc          = ctrl_g.pc_src;
  assign ALUOp          = ctrl_g.alu_op;
  assign instr_done     = ctrl_g.instr_done;
  assign illegal_op     = ~reset & (state_q == ST_DECODE) & ~opc_legal(opc);
  assign instr_count    = reset ? '0 : cnt_q;
  assign dbg_state_o    = reset ? ST_FETCH : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-cycle strobe sequences per instruction.
// Honors MC_CTRL_JR_EN the same way as the design.
module tb_mc_control_fsm;

  // Valid/ready is not used here: inputs are driven 1 time unit after each
  // rising edge and every output is sampled on the following falling edge.
  logic       clk, reset, Zero;
  logic [5:0] opc, fn;
  wire [18:0] got, got4;
  wire [31:0] cnt;
  wire [3:0]  cnt4, dbg, dbg4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opc(opc), .fn(fn), .Zero(Zero),
    .PCWrite(got[18]), .PCWriteControl(got[17]), .IorD(got[16]), .MemRead(got[15]),
    .MemWrite(got[14]), .IRWrite(got[13]), .MemtoReg(got[12]), .RegWrite(got[11]),
    .RegDst(got[10]), .ALUSelA(got[9]), .TargetWrite(got[8]), .ALUSelB(got[7:6]),
    .PCSrc(got[5:4]), .ALUOp(got[3:2]), .instr_done(got[1]), .illegal_op(got[0]),
    .instr_count(cnt), .dbg_state_o(dbg)
  );

  mc_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opc(opc), .fn(fn), .Zero(Zero),
    .PCWrite(got4[18]), .PCWriteControl(got4[17]), .IorD(got4[16]), .MemRead(got4[15]),
    .MemWrite(got4[14]), .IRWrite(got4[13]), .MemtoReg(got4[12]), .RegWrite(got4[11]),
    .RegDst(got4[10]), .ALUSelA(got4[9]), .TargetWrite(got4[8]), .ALUSelB(got4[7:6]),
    .PCSrc(got4[5:4]), .ALUOp(got4[3:2]), .instr_done(got4[1]), .illegal_op(got4[0]),
    .instr_count(cnt4), .dbg_state_o(dbg4)
  );

  localparam logic [18:0] B_PCW  = 19'b1 << 18;
  localparam logic [18:0] B_IORD = 19'b1 << 16;
  localparam logic [18:0] B_MR   = 19'b1 << 15;
  localparam logic [18:0] B_MW   = 19'b1 << 14;
  localparam logic [18:0] B_IRW  = 19'b1 << 13;
  localparam logic [18:0] B_M2R  = 19'b1 << 12;
  localparam logic [18:0] B_RW   = 19'b1 << 11;
  localparam logic [18:0] B_RD   = 19'b1 << 10;
  localparam logic [18:0] B_SA   = 19'b1 << 9;
  localparam logic [18:0] B_TW   = 19'b1 << 8;
  localparam logic [18:0] B_DONE = 19'b1 << 1;
  localparam logic [18:0] B_ILL  = 19'b1;

  logic [18:0] exp_q[$];
  logic [31:0] m_cnt;
  int          n_checks, n_fail;

  function automatic logic [18:0] sel(input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [1:0] op);
    return {11'b0, sb, ps, op, 2'b00};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  // Expected output vector for every cycle of one instruction, from FETCH onward.
  task automatic build_seq(input logic [5:0] o, input logic [5:0] f, input logic zb);
    exp_q.delete();
    exp_q.push_back(B_PCW | B_MR | B_IRW | sel(2'b01, 2'b00, 2'b00));
    case (o)
      6'b100011: begin
        exp_q.push_back(B_TW);
        exp_q.push_back(B_SA | sel(2'b10, 2'b00, 2'b00));
        exp_q.push_back(B_IORD | B_MR | B_SA | sel(2'b10, 2'b00, 2'b00));
        exp_q.push_back(B_M2R | B_RW | B_DONE);
      end
      6'b101011: begin
        exp_q.push_back(B_TW);
        exp_q.push_back(B_SA | sel(2'b10, 2'b00, 2'b00));
        exp_q.push_back(B_IORD | B_MW | B_SA | sel(2'b10, 2'b00, 2'b00) | B_DONE);
      end
      6'b000100: begin
        exp_q.push_back(B_TW);
        exp_q.push_back(B_SA | sel(2'b00, 2'b00, 2'b01));
        exp_q.push_back((zb ? B_PCW : 19'b0) | sel(2'b11, 2'b01, 2'b00) | B_DONE);
      end
      6'b000010: begin
        exp_q.push_back(B_TW);
        exp_q.push_back(B_PCW | sel(2'b00, 2'b10, 2'b00) | B_DONE);
      end
      6'b001000: begin
        exp_q.push_back(B_TW);
        exp_q.push_back(B_SA | sel(2'b10, 2'b00, 2'b00) | B_RW | B_DONE);
      end
      6'b000000: begin
        exp_q.push_back(B_TW);
`ifdef MC_CTRL_JR_EN
        if (f == 6'b001000) exp_q.push_back(B_PCW | sel(2'b00, 2'b11, 2'b00) | B_DONE);
        else
`endif
        exp_q.push_back(B_SA | sel(2'b00, 2'b00, 2'b10) | B_RD | B_RW | B_DONE);
      end
      default: exp_q.push_back(B_TW | B_ILL);
    endcase
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      reset = 1'b1;
      opc   = 6'($urandom_range(0, 63));
      Zero  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("rst_out", {13'b0, got}, 32'd0);
      check_eq("rst_cnt", cnt, 32'd0);
      check_eq("rst_out4", {13'b0, got4}, 32'd0);
    end
    m_cnt = 0;
  endtask

  // zmode: 0/1 force Zero, 2 randomizes it each cycle. abort_at < 0 runs to completion.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input int abort_at);
    logic        z[5];
    logic [18:0] e;
    int          n;
    for (int i = 0; i < 5; i++) z[i] = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
    build_seq(o, f, z[2]);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      reset = (c == abort_at);
      opc   = o;
      fn    = f;
      Zero  = z[c];
      e     = exp_q.pop_front();
      if (c == abort_at) e = '0;
      @(negedge clk);
      check_eq("strobes", {13'b0, got}, {13'b0, e});
      check_eq("strobes4", {13'b0, got4}, {13'b0, e});
      check_eq("count", cnt, (c == abort_at) ? 32'd0 : m_cnt);
      check_eq("count4", {28'b0, cnt4}, (c == abort_at) ? 32'd0 : {28'b0, m_cnt[3:0]});
      if (c == abort_at) begin
        m_cnt = 0;
        break;
      end
      if (e[1]) m_cnt++;
    end
  endtask

  initial begin
    logic [5:0] tbl[6];
    logic [5:0] o, f;
    tbl[0] = 6'b000000; tbl[1] = 6'b100011; tbl[2] = 6'b101011;
    tbl[3] = 6'b000100; tbl[4] = 6'b000010; tbl[5] = 6'b001000;
    n_checks = 0; n_fail = 0; m_cnt = 0;
    reset = 1'b1; opc = '0; fn = '0; Zero = 1'b0;

    do_reset(3);
    run_instr(6'b100011, 6'd0, 2, -1);
    run_instr(6'b000100, 6'd0, 1, -1);
    run_instr(6'b000100, 6'd0, 0, -1);
    run_instr(6'b000010, 6'd0, 2, -1);
    run_instr(6'b000000, 6'b001000, 2, -1);
    run_instr(6'b000000, 6'b100000, 2, -1);
    run_instr(6'b111111, 6'd0, 2, -1);
    run_instr(6'b101011, 6'd0, 2, -1);
    run_instr(6'b001000, 6'd0, 2, -1);
    run_instr(6'b100011, 6'd0, 2, 3);
    run_instr(6'b101011, 6'd0, 2, -1);
    run_instr(6'b000000, 6'b100010, 2, -1);

    do_reset(1);
    repeat (16) run_instr(6'b001000, 6'($urandom_range(0, 63)), 2, -1);
    check_eq("wrap_model", m_cnt, 32'd16);

    repeat (300) begin
      o = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : tbl[$urandom_range(0, 5)];
      f = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom_range(0, 63));
      run_instr(o, f, 2, ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
